cc1200_spi_top: RTL and testbench
=================================

CC1200_SPI_TOP -- requirements
Module: cc1200_spi_top

Interface
REQ-001 Parameter GPIO_W, 4, GPIO bit count.
REQ-002 Parameter DIV_W, 16, clock-divider register width.
REQ-003 clk  in  1  single clock for APB, SPI engine and stream port.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 paddr  in  32  APB address; bits [5:2] decode, other bits ignored.
REQ-006 psel, penable, pwrite  in  1 each  APB control.
REQ-007 pwdata  in  32  APB write data.
REQ-008 prdata  out  32  APB read data.
REQ-009 pready  out  1  APB ready.
REQ-010 pslverr  out  1  APB error, constant 0.
REQ-011 get_data_en  in  1  stream word available.
REQ-012 get_data  in  12  stream word.
REQ-013 next_data  out  1  one-cycle pop strobe for the stream source.
REQ-014 sclk, mosi, cs_n  out  1 each  SPI master outputs.
REQ-015 miso  in  1  SPI master input.
REQ-016 gpio_o, gpio_oe  out  GPIO_W each  GPIO value and output-enable.
REQ-017 gpio_i  in  GPIO_W  GPIO input.

Function
REQ-018 APB: zero wait state; pready = psel & penable; write commits on psel&penable&pwrite; prdata combinational from paddr during access phase, 0 for unmapped addresses.
REQ-019 Register map: 0x00 CTRL (W: bit0 START, bit1 STREAM, bit2 STOP, self-clearing pulses; R: bit0 = stream mode active); 0x04 STATUS (R bit0 = busy); 0x08 DATA_OUT (RW 32); 0x0C DATA_IN (R 32); 0x10 BYTE_NUM (RW, bits [1:0] used); 0x14 CLK_DIV (RW, DIV_W); 0x18 GPIO_OE (RW); 0x1C GPIO_OUT (RW); 0x20 GPIO_IN (R).
REQ-020 SPI mode 0, MSB first; mosi updates on sclk falling edge (first bit before first rising edge); miso sampled on sclk rising edge.
REQ-021 sclk half-period = CLK_DIV clk cycles; CLK_DIV = 0 treated as 1; sclk idles low.
REQ-022 cs_n falls one half-period before the first rising sclk edge and rises one half-period after the last falling edge.
REQ-023 Register transfer (START): N = BYTE_NUM[1:0]+1 bytes; shifts DATA_OUT[8N-1:0] MSB first; DATA_IN receives the 8N sampled bits right-aligned, upper bits zero, updated when cs_n rises.
REQ-024 State machine: IDLE -> SETUP (cs_n low) -> SHIFT (8N or 16 bits) -> HOLD -> IDLE, or -> SETUP-free SHIFT of next stream word in stream mode.
REQ-025 busy = 1 from the cycle after START/stream word accept until cs_n returns high.
REQ-026 START while busy or in stream mode is ignored; register writes to DATA_OUT/BYTE_NUM/CLK_DIV while busy take effect at the next transfer only.
REQ-027 STREAM sets stream mode; while in stream mode and the engine is ready, get_data_en = 1 causes latch of get_data, next_data pulse for exactly one cycle, and transmission of 16 bits {4'h0, get_data}; cs_n stays low between back-to-back words.
REQ-028 Stream mode exits on STOP: current word completes, cs_n rises, stream-active bit clears; STOP outside stream mode has no effect.
REQ-029 If get_data_en is low when a stream word completes, cs_n rises and the engine waits in stream mode for get_data_en.
REQ-030 gpio_o = GPIO_OUT, gpio_oe = GPIO_OE; GPIO_IN returns gpio_i through a 2-flop synchronizer.

Reset
REQ-031 On rst: all registers 0, stream mode off, busy 0, cs_n = 1, sclk = 0, mosi = 0, next_data = 0, gpio_oe = 0, prdata = 0.
REQ-032 rst asserted mid-transfer aborts immediately to IDLE with the above values; no partial DATA_IN update.

Verification
REQ-033 GPIO: write 0x18=0xF, 0x1C=0xA -> gpio_o=0xA, gpio_oe=0xF; drive gpio_i=0x5, read 0x20 after 3 cycles -> 0x5.
REQ-034 CLK_DIV=4, BYTE_NUM=1, DATA_OUT=0x00B3456D, START -> 16 sclk pulses, period 8 clk, mosi = 0x456D MSB first; STATUS polls 1 then 0; miso fixed pattern 0x1234 -> DATA_IN=0x00001234.
REQ-035 BYTE_NUM=0, START -> exactly 8 sclk pulses, mosi = 0x6D.
REQ-036 STREAM with get_data_en=1, words 0x7F7, 0x6E6 -> one next_data pulse per word, mosi 0x07F7 then 0x06E6, cs_n low throughout; STOP -> cs_n high after current word, CTRL read = 0.
REQ-037 START written during busy -> ignored, single transfer observed.
REQ-038 rst pulse mid-transfer -> cs_n=1, sclk=0, STATUS=0 immediately, DATA_IN unchanged (0).

Source files
------------

// File: rtl/cc1200_spi_top_if.sv
// APB slave bus plus 12-bit stream handshake used by the CC1200 SPI master.
interface cc1200_spi_top_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        get_data_en;
  logic [11:0] get_data;
  logic        next_data;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, get_data_en, get_data,
    input  prdata, pready, pslverr, next_data
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, get_data_en, get_data,
    output prdata, pready, pslverr, next_data
  );
endinterface

// File: rtl/cc1200_spi_top.sv
// CC1200 SPI mode-0 master with APB register file, 12-bit stream feed and GPIO.
// Divider, length and TX data are latched at transfer start, so writes while busy apply next time.
module cc1200_spi_top #(
  parameter int GPIO_W = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  cc1200_spi_top_if.slave   bus,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  input  logic [GPIO_W-1:0] gpio_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              stream_q, stream_d;
  logic              stop_pend_q, stop_pend_d;
  logic              xfer_str_q, xfer_str_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [31:0]       data_in_q, data_in_d;
  logic [1:0]        byte_num_q, byte_num_d;
  logic [DIV_W-1:0]  clk_div_q, clk_div_d;
  logic [GPIO_W-1:0] gpio_oe_q, gpio_oe_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s2_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bits_q, bits_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              next_q, next_d;

  logic [3:0]        idx_s;
  logic              wr_s, start_w_s, stream_w_s, stop_w_s;
  logic              idle_s, start_acc_s, str_go_s, half_s;
  logic [DIV_W-1:0]  eff_div_s;
  logic [5:0]        nbits_s;
  logic [31:0]       tx_load_s, word_s, rdata_s;
  logic              unused_s;

  assign idx_s       = bus.paddr[5:2];
  assign unused_s    = ^{bus.paddr[31:6], bus.paddr[1:0]};
  assign wr_s        = bus.psel & bus.penable & bus.pwrite;
  assign start_w_s   = wr_s & (idx_s == 4'd0) & bus.pwdata[0];
  assign stream_w_s  = wr_s & (idx_s == 4'd0) & bus.pwdata[1];
  assign stop_w_s    = wr_s & (idx_s == 4'd0) & bus.pwdata[2];
  assign idle_s      = (state_q == S_IDLE);
  assign start_acc_s = start_w_s & idle_s & ~stream_q & ~stream_w_s;
  // A pending or simultaneous STOP blocks any further stream word.
  assign str_go_s    = stream_q & ~stop_pend_q & ~stop_w_s & bus.get_data_en;
  assign half_s      = (cnt_q == (div_q - DIV_W'(1)));
  assign eff_div_s   = (clk_div_q == {DIV_W{1'b0}}) ? DIV_W'(1) : clk_div_q;
  assign nbits_s     = {({1'b0, byte_num_q} + 3'd1), 3'b000};
  assign tx_load_s   = data_out_q << (6'd32 - nbits_s);
  assign word_s      = {4'h0, bus.get_data, 16'h0000};

  // Next-state logic for the register file and the shift engine.
  always_comb begin
    state_d     = state_q;
    stream_d    = stream_q;
    xfer_str_d  = xfer_str_q;
    data_out_d  = data_out_q;
    data_in_d   = data_in_q;
    byte_num_d  = byte_num_q;
    clk_div_d   = clk_div_q;
    gpio_oe_d   = gpio_oe_q;
    gpio_out_d  = gpio_out_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    next_d      = 1'b0;
    stop_pend_d = stop_pend_q | (stop_w_s & stream_q & ~idle_s);

    if (wr_s) begin
      case (idx_s)
        4'd2:    data_out_d = bus.pwdata;
        4'd4:    byte_num_d = bus.pwdata[1:0];
        4'd5:    clk_div_d  = bus.pwdata[DIV_W-1:0];
        4'd6:    gpio_oe_d  = bus.pwdata[GPIO_W-1:0];
        4'd7:    gpio_out_d = bus.pwdata[GPIO_W-1:0];
        default: data_out_d = data_out_q;
      endcase
    end else begin
      data_out_d = data_out_q;
    end

    if (stream_w_s) begin
      stream_d = 1'b1;
    end else if (stop_w_s && stream_q && idle_s) begin
      stream_d = 1'b0;
    end else begin
      stream_d = stream_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = {DIV_W{1'b0}};
        div_d = eff_div_s;
        rx_d  = 32'h0;
        if (start_acc_s) begin
          tx_d       = tx_load_s;
          bits_d     = nbits_s;
          mosi_d     = tx_load_s[31];
          cs_n_d     = 1'b0;
          xfer_str_d = 1'b0;
          state_d    = S_SETUP;
        end else if (str_go_s) begin
          tx_d       = word_s;
          bits_d     = 6'd16;
          mosi_d     = 1'b0;
          cs_n_d     = 1'b0;
          next_d     = 1'b1;
          xfer_str_d = 1'b1;
          state_d    = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (half_s) begin
          cnt_d   = {DIV_W{1'b0}};
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], miso};
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (!half_s) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else if (!sclk_q) begin
          cnt_d  = {DIV_W{1'b0}};
          sclk_d = 1'b1;
          rx_d   = {rx_q[30:0], miso};
        end else begin
          cnt_d  = {DIV_W{1'b0}};
          sclk_d = 1'b0;
          if (bits_q != 6'd1) begin
            bits_d = bits_q - 6'd1;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[30];
          end else if (xfer_str_q && str_go_s) begin
            // Back-to-back stream word: no SETUP, cs_n stays low.
            tx_d   = word_s;
            bits_d = 6'd16;
            mosi_d = 1'b0;
            next_d = 1'b1;
          end else begin
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (half_s) begin
          cnt_d   = {DIV_W{1'b0}};
          cs_n_d  = 1'b1;
          state_d = S_IDLE;
          if (!xfer_str_q) begin
            data_in_d = rx_q;
          end else begin
            data_in_d = data_in_q;
          end
          if (stop_pend_q) begin
            stream_d    = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            stop_pend_d = stop_pend_q;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stream_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      xfer_str_q  <= 1'b0;
      data_out_q  <= 32'h0;
      data_in_q   <= 32'h0;
      byte_num_q  <= 2'd0;
      clk_div_q   <= {DIV_W{1'b0}};
      gpio_oe_q   <= {GPIO_W{1'b0}};
      gpio_out_q  <= {GPIO_W{1'b0}};
      gpio_s1_q   <= {GPIO_W{1'b0}};
      gpio_s2_q   <= {GPIO_W{1'b0}};
      cnt_q       <= {DIV_W{1'b0}};
      div_q       <= DIV_W'(1);
      bits_q      <= 6'd0;
      tx_q        <= 32'h0;
      rx_q        <= 32'h0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      next_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stream_q    <= stream_d;
      stop_pend_q <= stop_pend_d;
      xfer_str_q  <= xfer_str_d;
      data_out_q  <= data_out_d;
      data_in_q   <= data_in_d;
      byte_num_q  <= byte_num_d;
      clk_div_q   <= clk_div_d;
      gpio_oe_q   <= gpio_oe_d;
      gpio_out_q  <= gpio_out_d;
      gpio_s1_q   <= gpio_i;
      gpio_s2_q   <= gpio_s1_q;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      next_q      <= next_d;
    end
  end

  // APB read mux.
  always_comb begin
    rdata_s = 32'h0;
    case (idx_s)
      4'd0:    rdata_s[0] = stream_q;
      4'd1:    rdata_s[0] = ~idle_s;
      4'd2:    rdata_s = data_out_q;
      4'd3:    rdata_s = data_in_q;
      4'd4:    rdata_s[1:0] = byte_num_q;
      4'd5:    rdata_s[DIV_W-1:0] = clk_div_q;
      4'd6:    rdata_s[GPIO_W-1:0] = gpio_oe_q;
      4'd7:    rdata_s[GPIO_W-1:0] = gpio_out_q;
      4'd8:    rdata_s[GPIO_W-1:0] = gpio_s2_q;
      default: rdata_s = 32'h0;
    endcase
  end

  assign bus.prdata    = (bus.psel & bus.penable) ? rdata_s : 32'h0;
  assign bus.pready    = bus.psel & bus.penable;
  assign bus.pslverr   = 1'b0;
  assign bus.next_data = next_q;
  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign cs_n          = cs_n_q;
  assign gpio_o        = gpio_out_q;
  assign gpio_oe       = gpio_oe_q;

endmodule

// File: tb/tb_cc1200_spi_top.sv
// Directed self-checking bench for cc1200_spi_top: APB map, SPI shifting, stream mode, reset abort.
module tb_cc1200_spi_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk, mosi, cs_n, miso;
  logic [3:0] gpio_o, gpio_oe;
  logic [3:0] gpio_i = 4'h0;
  int         checks = 0;
  int         passed = 0;
  int         rise_cnt = 0;
  int         csn_rise = 0;
  int         nd_cnt = 0;
  int         miso_base = 0;
  logic [15:0] miso_pat = 16'h0;
  logic       mosi_hist[$];
  time        rise_t[$];

  cc1200_spi_top_if bus ();

  cc1200_spi_top #(.GPIO_W(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .gpio_o(gpio_o), .gpio_oe(gpio_oe), .gpio_i(gpio_i)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    mosi_hist.push_back(mosi);
    rise_t.push_back($time);
    rise_cnt <= rise_cnt + 1;
  end

  always @(posedge cs_n) csn_rise <= csn_rise + 1;

  always @(posedge clk) if (bus.next_data) nd_cnt <= nd_cnt + 1;

  // Slave model: bit k of the pattern (MSB first) is presented before the k-th rising edge.
  assign miso = ((rise_cnt - miso_base) >= 0 && (rise_cnt - miso_base) < 16) ?
                miso_pat[4'(15 - (rise_cnt - miso_base))] : 1'b0;

  function automatic logic [31:0] mosi_word(input int start, input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n; i++) w = {w[30:0], mosi_hist[start + i]};
    return w;
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwdata = d;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = a;
    @(negedge clk);
    bus.penable = 1'b1;
    #1 d = bus.prdata;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wait_idle(output bit done);
    logic [31:0] st;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      apb_read(32'h04, st);
      if (st == 32'h0) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", cs_n); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk); else passed++;
    checks++; if (mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi); else passed++;
    checks++; if (bus.next_data !== 1'b0) $display("FAIL rst_next: got %b want 0", bus.next_data); else passed++;
    checks++; if (gpio_oe !== 4'h0) $display("FAIL rst_gpio_oe: got %h want 0", gpio_oe); else passed++;
    checks++; if (bus.prdata !== 32'h0) $display("FAIL rst_prdata: got %h want 0", bus.prdata); else passed++;
    rst = 1'b0;
    apb_read(32'h04, r);
    checks++; if (r !== 32'h0) $display("FAIL rst_status: got %h want 0", r); else passed++;
    apb_read(32'h00, r);
    checks++; if (r !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", r); else passed++;
  endtask

  task automatic test_gpio();
    logic [31:0] r;
    apb_write(32'h18, 32'hF);
    apb_write(32'h1C, 32'hA);
    checks++; if (gpio_o !== 4'hA) $display("FAIL gpio_o: got %h want a", gpio_o); else passed++;
    checks++; if (gpio_oe !== 4'hF) $display("FAIL gpio_oe: got %h want f", gpio_oe); else passed++;
    gpio_i = 4'h5;
    repeat (3) @(negedge clk);
    apb_read(32'h20, r);
    checks++; if (r !== 32'h5) $display("FAIL gpio_in: got %h want 5", r); else passed++;
    apb_read(32'h5C, r);
    checks++; if (r !== 32'hA) $display("FAIL gpio_alias: got %h want a", r); else passed++;
    apb_read(32'h24, r);
    checks++; if (r !== 32'h0) $display("FAIL unmapped: got %h want 0", r); else passed++;
  endtask

  task automatic test_reg_xfer();
    logic [31:0] r;
    bit done;
    int s, c0;
    apb_write(32'h14, 32'd4);
    apb_write(32'h10, 32'd1);
    apb_write(32'h08, 32'h00B3456D);
    miso_pat = 16'h1234; miso_base = rise_cnt; s = mosi_hist.size(); c0 = csn_rise;
    apb_write(32'h00, 32'h1);
    apb_read(32'h04, r);
    checks++; if (r !== 32'h1) $display("FAIL xfer_busy: got %h want 1", r); else passed++;
    wait_idle(done);
    checks++; if (done !== 1'b1) $display("FAIL xfer_timeout: got %b want 1", done); else passed++;
    checks++; if (mosi_hist.size() - s !== 16) $display("FAIL xfer_pulses: got %0d want 16", mosi_hist.size() - s); else passed++;
    checks++; if (mosi_word(s, 16) !== 32'h456D) $display("FAIL xfer_mosi: got %h want 456d", mosi_word(s, 16)); else passed++;
    checks++; if (rise_t[s + 15] - rise_t[s] !== 64'd1200) $display("FAIL xfer_period: got %0d want 1200", rise_t[s + 15] - rise_t[s]); else passed++;
    apb_read(32'h0C, r);
    checks++; if (r !== 32'h00001234) $display("FAIL xfer_data_in: got %h want 00001234", r); else passed++;
    checks++; if (csn_rise - c0 !== 1 || cs_n !== 1'b1) $display("FAIL xfer_cs: got rises %0d cs_n %b want 1 1", csn_rise - c0, cs_n); else passed++;
  endtask

  task automatic test_one_byte();
    logic [31:0] r;
    bit done;
    int s;
    apb_write(32'h10, 32'd0);
    miso_base = rise_cnt; s = mosi_hist.size();
    apb_write(32'h00, 32'h1);
    wait_idle(done);
    checks++; if (mosi_hist.size() - s !== 8) $display("FAIL byte_pulses: got %0d want 8", mosi_hist.size() - s); else passed++;
    checks++; if (mosi_word(s, 8) !== 32'h6D) $display("FAIL byte_mosi: got %h want 6d", mosi_word(s, 8)); else passed++;
    apb_read(32'h0C, r);
    checks++; if (r !== 32'h12) $display("FAIL byte_data_in: got %h want 12", r); else passed++;
  endtask

  task automatic test_div_zero();
    bit done;
    int s;
    apb_write(32'h14, 32'd0);
    s = mosi_hist.size();
    apb_write(32'h00, 32'h1);
    wait_idle(done);
    checks++; if (mosi_word(s, 8) !== 32'h6D) $display("FAIL div0_mosi: got %h want 6d", mosi_word(s, 8)); else passed++;
    checks++; if (rise_t[s + 7] - rise_t[s] !== 64'd140) $display("FAIL div0_period: got %0d want 140", rise_t[s + 7] - rise_t[s]); else passed++;
  endtask

  task automatic test_busy_start();
    logic [31:0] r;
    bit done;
    int s;
    apb_write(32'h14, 32'd4);
    apb_write(32'h10, 32'd1);
    s = mosi_hist.size();
    apb_write(32'h00, 32'h1);
    apb_write(32'h00, 32'h1);
    apb_write(32'h08, 32'hFFFFFFFF);
    wait_idle(done);
    repeat (60) @(negedge clk);
    checks++; if (mosi_hist.size() - s !== 16) $display("FAIL busy_pulses: got %0d want 16", mosi_hist.size() - s); else passed++;
    checks++; if (mosi_word(s, 16) !== 32'h456D) $display("FAIL busy_mosi: got %h want 456d", mosi_word(s, 16)); else passed++;
    apb_read(32'h08, r);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL busy_data_out: got %h want ffffffff", r); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] r;
    bit done;
    int s, c0, n0;
    apb_write(32'h14, 32'd2);
    s = mosi_hist.size(); c0 = csn_rise; n0 = nd_cnt;
    bus.get_data = 12'h7F7; bus.get_data_en = 1'b1;
    apb_write(32'h00, 32'h2);
    apb_read(32'h00, r);
    checks++; if (r !== 32'h1) $display("FAIL stream_ctrl_on: got %h want 1", r); else passed++;
    for (int i = 0; i < 400 && nd_cnt < n0 + 1; i++) @(negedge clk);
    bus.get_data = 12'h6E6;
    for (int i = 0; i < 400 && nd_cnt < n0 + 2; i++) @(negedge clk);
    bus.get_data_en = 1'b0;
    apb_write(32'h00, 32'h4);
    wait_idle(done);
    checks++; if (done !== 1'b1) $display("FAIL stream_timeout: got %b want 1", done); else passed++;
    checks++; if (nd_cnt - n0 !== 2) $display("FAIL stream_next: got %0d want 2", nd_cnt - n0); else passed++;
    checks++; if (mosi_hist.size() - s !== 32) $display("FAIL stream_pulses: got %0d want 32", mosi_hist.size() - s); else passed++;
    checks++; if (mosi_word(s, 32) !== 32'h07F706E6) $display("FAIL stream_mosi: got %h want 07f706e6", mosi_word(s, 32)); else passed++;
    checks++; if (csn_rise - c0 !== 1 || cs_n !== 1'b1) $display("FAIL stream_cs: got rises %0d cs_n %b want 1 1", csn_rise - c0, cs_n); else passed++;
    apb_read(32'h00, r);
    checks++; if (r !== 32'h0) $display("FAIL stream_ctrl_off: got %h want 0", r); else passed++;
  endtask

  task automatic test_stream_gap();
    logic [31:0] r;
    bit done;
    int s, c0, n0;
    apb_write(32'h14, 32'd1);
    s = mosi_hist.size(); c0 = csn_rise; n0 = nd_cnt;
    bus.get_data = 12'h0A5; bus.get_data_en = 1'b1;
    apb_write(32'h00, 32'h2);
    for (int i = 0; i < 400 && nd_cnt < n0 + 1; i++) @(negedge clk);
    bus.get_data_en = 1'b0;
    wait_idle(done);
    apb_read(32'h00, r);
    checks++; if (r !== 32'h1) $display("FAIL gap_ctrl: got %h want 1", r); else passed++;
    checks++; if (csn_rise - c0 !== 1) $display("FAIL gap_cs: got %0d want 1", csn_rise - c0); else passed++;
    bus.get_data = 12'h15A; bus.get_data_en = 1'b1;
    for (int i = 0; i < 400 && nd_cnt < n0 + 2; i++) @(negedge clk);
    bus.get_data_en = 1'b0;
    apb_write(32'h00, 32'h4);
    wait_idle(done);
    checks++; if (mosi_word(s, 32) !== 32'h00A5015A) $display("FAIL gap_mosi: got %h want 00a5015a", mosi_word(s, 32)); else passed++;
    checks++; if (csn_rise - c0 !== 2) $display("FAIL gap_cs2: got %0d want 2", csn_rise - c0); else passed++;
    apb_read(32'h00, r);
    checks++; if (r !== 32'h0) $display("FAIL gap_ctrl_off: got %h want 0", r); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int p;
    apb_write(32'h14, 32'd4);
    apb_write(32'h10, 32'd1);
    apb_write(32'h00, 32'h1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    p = mosi_hist.size();
    checks++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", cs_n); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", sclk); else passed++;
    @(negedge clk);
    rst = 1'b0;
    apb_read(32'h04, r);
    checks++; if (r !== 32'h0) $display("FAIL mid_status: got %h want 0", r); else passed++;
    apb_read(32'h0C, r);
    checks++; if (r !== 32'h0) $display("FAIL mid_data_in: got %h want 0", r); else passed++;
    repeat (60) @(negedge clk);
    checks++; if (mosi_hist.size() !== p) $display("FAIL mid_no_pulses: got %0d want %0d", mosi_hist.size(), p); else passed++;
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pwdata = 32'h0;
    bus.get_data_en = 1'b0; bus.get_data = 12'h0;
    test_reset();
    test_gpio();
    test_reg_xfer();
    test_one_byte();
    test_div_zero();
    test_busy_start();
    test_stream();
    test_stream_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
